// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - Shared addresses, status bit positions and frame states for the buffered SPART
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int STAT_TBR        = 0;
  localparam int STAT_RDA        = 1;
  localparam int STAT_TX_EMPTY   = 2;
  localparam int STAT_OVERRUN    = 3;
  localparam int STAT_PARITY_ERR = 4;
  localparam int STAT_FRAME_ERR  = 5;
  localparam int STAT_TX_BUSY    = 6;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} frame_state_t;

endpackage

// File: rtl/spart_if.sv
// rtl/spart_if.sv - Processor-side bus strobes and FIFO flags of the buffered SPART
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_sync_fifo.sv
// rtl/spart_sync_fifo.sv - Synchronous FIFO with wrap-bit pointers; push on full is accepted only alongside a pop
module spart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/spart_buffered.sv
// rtl/spart_buffered.sv - Bus-mapped UART with TX/RX FIFOs and 16x oversampling
// Optional parity support is built when SPART_PARITY_EN is defined.
module spart_buffered
  import spart_pkg::*;
#(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DEF_DIV    = 16'h0064
) (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus,
  output logic       txd,
  input  logic       rxd
);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic                 w_wr, w_rd, w_div_wr, w_tick, w_err_clr;
  logic [15:0]          r_div, r_baud_cnt, w_div_nxt;
  logic                 w_par_en, w_par_odd;
  logic                 r_frame_err, r_parity_err, r_overrun;
  logic                 w_set_ferr, w_set_perr, w_set_ovr;
  logic                 w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_load;
  logic                 w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [DATA_BITS-1:0] w_tx_head, w_rx_head;
  frame_state_t         r_tx_state, w_tx_state_nxt, r_rx_state, w_rx_state_nxt;
  logic [TICK_W-1:0]    r_tx_tick, w_tx_tick_nxt, r_rx_tick, w_rx_tick_nxt;
  logic [2:0]           r_tx_bit, w_tx_bit_nxt, r_rx_bit, w_rx_bit_nxt;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt, r_rx_shift, w_rx_shift_nxt;
  logic                 r_tx_par, w_tx_par_nxt, r_rx_par, w_rx_par_nxt, w_txd;
  logic                 r_rxd_s1, r_rxd_s2, r_rxd_s3, w_rx_fall;
  logic [7:0]           w_rdata, w_status, w_rx_byte;

  assign w_wr      = bus.iocs & ~bus.iorw;
  assign w_rd      = bus.iocs & bus.iorw;
  assign w_div_wr  = w_wr & bus.ioaddr[1];
  assign w_err_clr = w_wr & (bus.ioaddr == ADDR_STAT) & databus[7];
  assign w_tx_push = w_wr & (bus.ioaddr == ADDR_DATA);
  assign w_rx_pop  = w_rd & (bus.ioaddr == ADDR_DATA);

  always_comb begin
    w_div_nxt = r_div;
    if (w_wr && bus.ioaddr == ADDR_DBL) w_div_nxt[7:0]  = databus;
    if (w_wr && bus.ioaddr == ADDR_DBH) w_div_nxt[15:8] = databus;
  end

  assign w_tick = (r_baud_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= DEF_DIV;
      r_baud_cnt <= DEF_DIV;
    end else begin
      r_div <= w_div_nxt;
      if (w_div_wr)    r_baud_cnt <= w_div_nxt;
      else if (w_tick) r_baud_cnt <= r_div;
      else             r_baud_cnt <= r_baud_cnt - 16'd1;
    end
  end

`ifdef SPART_PARITY_EN
  logic [1:0] r_ctrl;

  always_ff @(posedge clk) begin
    if (rst)                                    r_ctrl <= 2'b00;
    else if (w_wr && bus.ioaddr == ADDR_STAT) r_ctrl <= databus[1:0];
  end

  assign w_par_en  = r_ctrl[0];
  assign w_par_odd = r_ctrl[1];
`else
  assign w_par_en  = 1'b0;
  assign w_par_odd = 1'b0;
`endif

  // Clear wins over any set arriving in the same cycle
  always_ff @(posedge clk) begin
    if (rst || w_err_clr) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_set_ferr) r_frame_err  <= 1'b1;
      if (w_set_perr) r_parity_err <= 1'b1;
      if (w_set_ovr)  r_overrun    <= 1'b1;
    end
  end

  spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .i_push(w_tx_push), .i_data(databus[DATA_BITS-1:0]),
    .i_pop(w_tx_pop), .o_data(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .i_push(w_rx_push), .i_data(r_rx_shift),
    .i_pop(w_rx_pop), .o_data(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_tx_tick  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_tick  <= w_tx_tick_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_par   <= w_tx_par_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_tick_nxt  = r_tx_tick;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_par_nxt   = r_tx_par;
    w_tx_pop       = 1'b0;
    w_tx_load      = 1'b0;
    if (w_tick) begin
      if (r_tx_state == IDLE) begin
        w_tx_load = !w_tx_empty;
      end else begin
        w_tx_tick_nxt = r_tx_tick + TICK_W'(1);
        if (r_tx_tick == TICK_LAST) begin
          case (r_tx_state)
            START: begin
              w_tx_state_nxt = DATA;
              w_tx_bit_nxt   = '0;
            end
            DATA: begin
              w_tx_shift_nxt = r_tx_shift >> 1;
              w_tx_bit_nxt   = r_tx_bit + 3'd1;
              if (r_tx_bit == BIT_LAST) w_tx_state_nxt = w_par_en ? PARITY : STOP;
            end
            PARITY: w_tx_state_nxt = STOP;
            default: begin
              w_tx_state_nxt = IDLE;
              w_tx_load      = !w_tx_empty;
            end
          endcase
        end
      end
    end
    // Shared by IDLE and back-to-back STOP: pop the head and start a frame
    if (w_tx_load) begin
      w_tx_pop       = 1'b1;
      w_tx_state_nxt = START;
      w_tx_tick_nxt  = '0;
      w_tx_shift_nxt = w_tx_head;
      w_tx_par_nxt   = (^w_tx_head) ^ w_par_odd;
    end
    case (r_tx_state)
      START:   w_txd = 1'b0;
      DATA:    w_txd = r_tx_shift[0];
      PARITY:  w_txd = r_tx_par;
      default: w_txd = 1'b1;
    endcase
  end

  assign txd = w_txd;

  assign w_rx_fall = r_rxd_s3 & ~r_rxd_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rxd_s3   <= 1'b1;
      r_rx_state <= IDLE;
      r_rx_tick  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
    end else begin
      r_rxd_s1   <= rxd;
      r_rxd_s2   <= r_rxd_s1;
      r_rxd_s3   <= r_rxd_s2;
      r_rx_state <= w_rx_state_nxt;
      r_rx_tick  <= w_rx_tick_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_par   <= w_rx_par_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_tick_nxt  = r_rx_tick;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_par_nxt   = r_rx_par;
    w_rx_push      = 1'b0;
    w_set_ferr     = 1'b0;
    w_set_perr     = 1'b0;
    w_set_ovr      = 1'b0;
    case (r_rx_state)
      IDLE: begin
        if (w_rx_fall) begin
          w_rx_state_nxt = START;
          w_rx_tick_nxt  = '0;
        end
      end
      START: begin
        if (w_tick) begin
          w_rx_tick_nxt = r_rx_tick + TICK_W'(1);
          // Mid-start re-check; from here every later sample is a full bit later
          if (r_rx_tick == TICK_MID) begin
            w_rx_tick_nxt  = '0;
            w_rx_bit_nxt   = '0;
            w_rx_state_nxt = r_rxd_s2 ? IDLE : DATA;
          end
        end
      end
      default: begin
        if (w_tick) begin
          w_rx_tick_nxt = r_rx_tick + TICK_W'(1);
          if (r_rx_tick == TICK_LAST) begin
            case (r_rx_state)
              DATA: begin
                w_rx_shift_nxt = {r_rxd_s2, r_rx_shift[DATA_BITS-1:1]};
                w_rx_bit_nxt   = r_rx_bit + 3'd1;
                if (r_rx_bit == BIT_LAST) w_rx_state_nxt = w_par_en ? PARITY : STOP;
              end
              PARITY: begin
                w_rx_par_nxt   = r_rxd_s2;
                w_rx_state_nxt = STOP;
              end
              default: begin
                w_rx_state_nxt = IDLE;
                if (!r_rxd_s2) begin
                  w_set_ferr = 1'b1;
                end else begin
                  w_set_perr = w_par_en & ((^r_rx_shift) ^ r_rx_par ^ w_par_odd);
                  if (w_rx_full && !w_rx_pop) w_set_ovr = 1'b1;
                  else                        w_rx_push = 1'b1;
                end
              end
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    w_rx_byte                  = 8'h00;
    w_rx_byte[DATA_BITS-1:0]   = w_rx_head;
    w_status                   = 8'h00;
    w_status[STAT_TBR]         = ~w_tx_full;
    w_status[STAT_RDA]         = ~w_rx_empty;
    w_status[STAT_TX_EMPTY]    = w_tx_empty;
    w_status[STAT_OVERRUN]     = r_overrun;
    w_status[STAT_PARITY_ERR]  = r_parity_err;
    w_status[STAT_FRAME_ERR]   = r_frame_err;
    w_status[STAT_TX_BUSY]     = (r_tx_state != IDLE);
    w_rdata                    = 8'h00;
    case (bus.ioaddr)
      ADDR_DATA: w_rdata = w_rx_empty ? 8'h00 : w_rx_byte;
      ADDR_STAT: w_rdata = w_status;
      ADDR_DBL:  w_rdata = r_div[7:0];
      default:   w_rdata = r_div[15:8];
    endcase
  end

  assign databus = w_rd ? w_rdata : 8'bz;
  assign bus.rda = ~w_rx_empty;
  assign bus.tbr = ~w_tx_full;
endmodule

// File: tb/tb_spart_buffered.sv
// tb/tb_spart_buffered.sv - Directed self-checking bench for spart_buffered
module tb_spart_buffered;
  logic       clk = 1'b0;
  logic       rst;
  logic       txd, rxd, rxd_drv, loop_en;
  logic [7:0] tb_drv;
  logic       tb_drv_en;
  wire  [7:0] databus;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  spart_if bus ();

  assign databus = tb_drv_en ? tb_drv : 8'bz;
  assign rxd     = loop_en ? txd : rxd_drv;

  spart_buffered dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .databus (databus),
    .txd     (txd),
    .rxd     (rxd)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; tb_drv = d; tb_drv_en = 1'b1;
    @(negedge clk);
    bus.iocs = 1'b0; tb_drv_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    bus.iocs = 1'b0; bus.iorw = 1'b0;
  endtask

  // One frame on rxd at divisor 0 (16 clocks per bit), followed by one idle bit
  task automatic send_rx(input logic [7:0] d, input logic use_par, input logic par, input logic stop_v);
    rxd_drv = 1'b0; repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i]; repeat (16) @(negedge clk);
    end
    if (use_par) begin
      rxd_drv = par; repeat (16) @(negedge clk);
    end
    rxd_drv = stop_v; repeat (16) @(negedge clk);
    rxd_drv = 1'b1;   repeat (16) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] pat;
    logic       found;
    logic       prev;
    int         nfr;

    bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
    tb_drv = 8'h00; tb_drv_en = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("txd_reset", 8'(txd), 8'h01);
    check("rda_reset", 8'(bus.rda), 8'h00);
    check("tbr_reset", 8'(bus.tbr), 8'h01);
    bus_rd(2'b01, d); check("status_reset", d, 8'h05);
    bus_rd(2'b10, d); check("div_lo_reset", d, 8'h64);
    bus_rd(2'b11, d); check("div_hi_reset", d, 8'h00);

    bus_wr(2'b11, 8'h00);
    bus_wr(2'b10, 8'h04);
    bus_rd(2'b10, d); check("div_lo_write", d, 8'h04);
    bus_wr(2'b00, 8'hA5);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    check("tx_start_seen", 8'(found), 8'h01);
    repeat (40) @(negedge clk);
    check("tx_start_bit", 8'(txd), 8'h00);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      repeat (80) @(negedge clk);
      check($sformatf("tx_data_bit%0d", i), 8'(txd), 8'(pat[i]));
    end
    repeat (80) @(negedge clk);
    check("tx_stop_bit", 8'(txd), 8'h01);
    bus_rd(2'b01, d); check("status_tx_busy", d, 8'h45);
    repeat (60) @(negedge clk);
    bus_rd(2'b01, d); check("status_tx_done", d, 8'h05);

    bus_wr(2'b10, 8'h40);
    for (int i = 0; i < 8; i++) bus_wr(2'b00, 8'hFF);
    check("tbr_full", 8'(bus.tbr), 8'h00);
    bus_rd(2'b01, d); check("status_tx_full", d, 8'h00);
    bus_wr(2'b00, 8'hFF);
    bus_wr(2'b10, 8'h00);
    nfr = 0; prev = txd;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && txd === 1'b0) nfr++;
      prev = txd;
    end
    check("tx_frame_count", 8'(nfr), 8'h08);
    bus_rd(2'b01, d); check("status_tx_drained", d, 8'h05);

    loop_en = 1'b1;
    check("rda_before_loop", 8'(bus.rda), 8'h00);
    bus_wr(2'b00, 8'h3C);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (bus.rda === 1'b1) found = 1'b1;
    end
    check("loop_rda_rise", 8'(found), 8'h01);
    bus_rd(2'b00, d); check("loop_data", d, 8'h3C);
    check("loop_rda_fall", 8'(bus.rda), 8'h00);
    repeat (40) @(negedge clk);
    loop_en = 1'b0;

    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    bus_rd(2'b01, d); check("status_frame_err", d, 8'h25);
    check("rda_after_frame_err", 8'(bus.rda), 8'h00);
    bus_wr(2'b01, 8'h80);
    bus_rd(2'b01, d); check("status_err_clear", d, 8'h05);

    rxd_drv = 1'b0; repeat (4) @(negedge clk);
    rxd_drv = 1'b1; repeat (40) @(negedge clk);
    bus_rd(2'b01, d); check("status_false_start", d, 8'h05);

    for (int i = 0; i < 9; i++) send_rx(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
    bus_rd(2'b01, d); check("status_overrun", d, 8'h0F);
    for (int i = 0; i < 8; i++) begin
      bus_rd(2'b00, d); check($sformatf("rx_fifo_data%0d", i), d, 8'(8'h10 + i));
    end
    check("rda_after_drain", 8'(bus.rda), 8'h00);
    bus_rd(2'b00, d); check("rx_read_empty", d, 8'h00);
    bus_rd(2'b01, d); check("status_overrun_sticky", d, 8'h0D);
    bus_wr(2'b01, 8'h80);

`ifdef SPART_PARITY_EN
    bus_wr(2'b01, 8'h01);
    send_rx(8'h07, 1'b1, 1'b0, 1'b1);
    bus_rd(2'b01, d); check("status_parity_err", d, 8'h17);
    bus_rd(2'b00, d); check("parity_err_data", d, 8'h07);
    bus_wr(2'b01, 8'h81);
    send_rx(8'h07, 1'b1, 1'b1, 1'b1);
    bus_rd(2'b01, d); check("status_parity_ok", d, 8'h07);
    bus_rd(2'b00, d); check("parity_ok_data", d, 8'h07);
`else
    bus_wr(2'b01, 8'h01);
    send_rx(8'h07, 1'b0, 1'b0, 1'b1);
    bus_rd(2'b01, d); check("status_no_parity", d, 8'h07);
    bus_rd(2'b00, d); check("no_parity_data", d, 8'h07);
`endif

    bus_wr(2'b00, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    check("midframe_start_seen", 8'(found), 8'h01);
    repeat (20) @(negedge clk);
    check("midframe_txd_low", 8'(txd), 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_txd", 8'(txd), 8'h01);
    rst = 1'b0;
    bus_rd(2'b01, d); check("status_after_reset", d, 8'h05);
    bus_rd(2'b10, d); check("div_lo_after_reset", d, 8'h64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
